florence_mem_arbiter: RTL

Shares one external memory port between the Florence core's instruction-fetch and load/store interfaces, for single-port memory systems. Arbitrates the two req/gnt/rvalid requesters onto the downstream port. Records the source of every granted transaction in an in-order tracking FIFO and routes each response back to the requester that issued it. Sits between `florence_core` and the memory/interconnect.

---
 rtl/florence_mem_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/florence_mem_arbiter.sv
// -----------------------------------------------------------------------------
// florence_mem_arbiter
//
// Shares one downstream memory port between the Florence core's instruction
// fetch (source 0) and load/store (source 1) requesters. Each granted
// transaction's source is recorded in an in-order tracking FIFO so that the
// in-order downstream responses can be routed back to the right requester.
//
// Configuration macro:
//   FLORENCE_MEM_ARB_RR_EN  defined   -> round-robin between the requesters
//                           undefined -> fixed priority, data over instr
//   In both modes a request that was presented downstream but not yet
//   granted keeps the port (lock) until it is granted.
//
// Parameters:
//   MaxOutstanding  granted-but-unanswered transactions allowed (1..4)
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   instr_req_i/gnt_o/rvalid_o      instruction requester handshake
//   instr_addr_i, instr_rdata_o, instr_err_o
//   data_req_i/gnt_o/rvalid_o       data requester handshake
//   data_we_i, data_be_i, data_addr_i, data_wdata_i, data_rdata_o, data_err_o
//   mem_req_o/gnt_i/rvalid_i        downstream handshake
//   mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_rdata_i, mem_err_i
//   busy_o                          tracking FIFO not empty (registered)
//   unexpected_rvalid_o             sticky: response arrived with FIFO empty
// -----------------------------------------------------------------------------
module florence_mem_arbiter #(
    parameter int MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        busy_o,
    output logic        unexpected_rvalid_o
);

    localparam int              PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [2:0]      Depth   = 3'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    // Tracking FIFO: one source bit per outstanding transaction.
    logic            r_fifo [MaxOutstanding];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [2:0]      r_count;
    logic            r_busy;
    logic            r_locked;
    logic            r_locked_src;
    logic            r_unexp;
`ifdef FLORENCE_MEM_ARB_RR_EN
    logic            r_last_src;
`endif

    logic            w_sel_valid;
    logic            w_sel;
    logic            w_empty;
    logic            w_full;
    logic            w_mem_req;
    logic            w_push;
    logic            w_pop;
    logic            w_head;
    logic [2:0]      w_count_next;
    logic [PtrW-1:0] w_wptr_inc;
    logic [PtrW-1:0] w_rptr_inc;

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count >= Depth);

    // Source selection. The lock has priority over the policy so that the
    // attributes seen downstream never change while a request is stalled.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = 1'b0;
        if (r_locked) begin
            w_sel_valid = 1'b1;
            w_sel       = r_locked_src;
        end else if (instr_req_i && data_req_i) begin
            w_sel_valid = 1'b1;
`ifdef FLORENCE_MEM_ARB_RR_EN
            w_sel       = ~r_last_src;
`else
            w_sel       = 1'b1;
`endif
        end else if (data_req_i) begin
            w_sel_valid = 1'b1;
            w_sel       = 1'b1;
        end else if (instr_req_i) begin
            w_sel_valid = 1'b1;
            w_sel       = 1'b0;
        end
    end

    // rst_ni gates every combinational output so nothing leaks out in reset.
    assign w_mem_req = rst_ni & w_sel_valid & ~w_full;
    assign w_push    = w_mem_req & mem_gnt_i;
    assign w_pop     = rst_ni & mem_rvalid_i & ~w_empty;
    assign w_head    = r_fifo[r_rptr];

    // Downstream attribute mux.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (rst_ni && w_sel_valid) begin
            if (w_sel) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    assign mem_req_o   = w_mem_req;
    assign instr_gnt_o = w_push & ~w_sel;
    assign data_gnt_o  = w_push &  w_sel;

    // Response routing: only the head source sees rdata/err.
    assign instr_rvalid_o = w_pop & ~w_head;
    assign data_rvalid_o  = w_pop &  w_head;
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;
    assign data_err_o     = data_rvalid_o  & mem_err_i;

    assign busy_o              = r_busy;
    assign unexpected_rvalid_o = r_unexp;

    assign w_wptr_inc = (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
    assign w_rptr_inc = (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 3'd1;
            2'b01:   w_count_next = r_count - 3'd1;
            default: w_count_next = r_count;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < MaxOutstanding; gi++) begin : g_fifo
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_fifo[gi] <= 1'b0;
                end else if (w_push && (r_wptr == PtrW'(gi))) begin
                    r_fifo[gi] <= w_sel;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= 3'd0;
            r_busy       <= 1'b0;
            r_locked     <= 1'b0;
            r_locked_src <= 1'b0;
            r_unexp      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_inc;
            end
            r_count <= w_count_next;
            r_busy  <= (w_count_next != 3'd0);
            // Presented but not accepted: hold this source until granted.
            r_locked <= w_mem_req & ~mem_gnt_i;
            if (w_mem_req && !mem_gnt_i) begin
                r_locked_src <= w_sel;
            end
            r_unexp <= r_unexp | (mem_rvalid_i & w_empty);
        end
    end

`ifdef FLORENCE_MEM_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_src <= 1'b0;
        end else if (w_push) begin
            r_last_src <= w_sel;
        end
    end
`endif

endmodule
